// File: rtl/uart_alu_frame_if.sv
// Framed UART<->ALU command interface: START, OP, A, B, CHK in; ACK/NAK plus result bytes out.
// Multi-byte operands, XOR checksum, inter-byte and ALU-wait timeout, saturating error count.
module uart_alu_frame_if #(
    parameter int unsigned                NB_BYTE     = 8,
    parameter int unsigned                NB_OP       = 6,
    parameter int unsigned                N_OPB       = 2,
    parameter logic        [NB_BYTE-1:0]  START_BYTE  = 8'hFF,
    parameter logic        [NB_BYTE-1:0]  ACK_BYTE    = 8'h06,
    parameter logic        [NB_BYTE-1:0]  NAK_BYTE    = 8'h15,
    parameter int unsigned                TIMEOUT_CYC = 50000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NB_BYTE-1:0]         rx_data,
    input  logic                       rx_empty,
    output logic                       rd,
    input  logic                       tx_full,
    output logic                       wr_tx,
    output logic [NB_BYTE-1:0]         tx_data,
    input  logic [NB_BYTE*N_OPB-1:0]   alu_result,
    input  logic                       alu_valid,
    output logic                       alu_start,
    output logic [NB_OP-1:0]           alu_op,
    output logic [NB_BYTE*N_OPB-1:0]   alu_a,
    output logic [NB_BYTE*N_OPB-1:0]   alu_b,
    output logic                       busy,
    output logic [7:0]                 err_cnt
);

    localparam int unsigned W  = NB_BYTE * N_OPB;
    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned IW = (N_OPB > 1) ? $clog2(N_OPB) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
    localparam logic [IW-1:0] ILAST = IW'(N_OPB - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GET_OP, S_GET_A, S_GET_B, S_GET_CHK, S_RUN, S_SEND_STAT, S_SEND_RES
    } state_e;

    state_e             state_q, state_d;
    logic [NB_OP-1:0]   op_q, op_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       res_q, res_d;
    logic [NB_BYTE-1:0] chk_q, chk_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [TW-1:0]      tmr_q, tmr_d;
    logic               nak_q, nak_d;
    logic               first_q, first_d;
    logic [7:0]         err_q, err_d;
    logic               err_inc;
    logic               timeout;

    assign alu_op  = op_q;
    assign alu_a   = a_q;
    assign alu_b   = b_q;
    assign err_cnt = err_q;
    assign timeout = (tmr_q == TMAX);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            chk_q   <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            nak_q   <= 1'b0;
            first_q <= 1'b0;
            err_q   <= '0;
        end else begin
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            chk_q   <= chk_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            nak_q   <= nak_d;
            first_q <= first_d;
            err_q   <= err_d;
        end
    end

    // Next-state and datapath update; rd doubles as the byte-consumed strobe
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        chk_d   = chk_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q + TW'(1);
        nak_d   = nak_q;
        first_d = 1'b0;
        err_inc = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (rd && rx_data == START_BYTE) state_d = S_GET_OP;
            end
            S_GET_OP: begin
                if (rd) begin
                    op_d    = rx_data[NB_OP-1:0];
                    chk_d   = rx_data;
                    idx_d   = '0;
                    tmr_d   = '0;
                    state_d = S_GET_A;
                end else if (timeout) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GET_A: begin
                if (rd) begin
                    a_d   = W'({a_q, rx_data});
                    chk_d = chk_q ^ rx_data;
                    tmr_d = '0;
                    if (idx_q == ILAST) begin
                        idx_d   = '0;
                        state_d = S_GET_B;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (timeout) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GET_B: begin
                if (rd) begin
                    b_d   = W'({b_q, rx_data});
                    chk_d = chk_q ^ rx_data;
                    tmr_d = '0;
                    if (idx_q == ILAST) begin
                        idx_d   = '0;
                        state_d = S_GET_CHK;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else if (timeout) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_GET_CHK: begin
                if (rd) begin
                    tmr_d = '0;
                    if (rx_data == chk_q) begin
                        first_d = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        nak_d   = 1'b1;
                        err_inc = 1'b1;
                        state_d = S_SEND_STAT;
                    end
                end else if (timeout) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (alu_valid) begin
                    res_d   = alu_result;
                    nak_d   = 1'b0;
                    tmr_d   = '0;
                    state_d = S_SEND_STAT;
                end else if (timeout) begin
                    nak_d   = 1'b1;
                    err_inc = 1'b1;
                    tmr_d   = '0;
                    state_d = S_SEND_STAT;
                end
            end
            S_SEND_STAT: begin
                tmr_d = '0;
                if (!tx_full) begin
                    idx_d   = '0;
                    state_d = nak_q ? S_IDLE : S_SEND_RES;
                end
            end
            S_SEND_RES: begin
                tmr_d = '0;
                if (!tx_full) begin
                    res_d = W'({res_q, NB_BYTE'(0)});
                    if (idx_q == ILAST) begin
                        idx_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    // FIFO handshakes and status outputs
    always_comb begin
        rd        = 1'b0;
        wr_tx     = 1'b0;
        tx_data   = '0;
        alu_start = 1'b0;
        busy      = (state_q != S_IDLE);
        unique case (state_q)
            S_IDLE, S_GET_OP, S_GET_A, S_GET_B, S_GET_CHK: rd = !rx_empty && !reset;
            S_RUN:       alu_start = first_q && !reset;
            S_SEND_STAT: begin
                wr_tx   = !tx_full && !reset;
                tx_data = nak_q ? NAK_BYTE : ACK_BYTE;
            end
            S_SEND_RES: begin
                wr_tx   = !tx_full && !reset;
                tx_data = res_q[W-1 -: NB_BYTE];
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_alu_frame_if.sv
// Bench for uart_alu_frame_if: queue-based RX FIFO and ALU stub, frame-level
// reference model of expected TX bytes, plus literal checks on directed frames.
module tb_uart_alu_frame_if;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_empty;
    logic          rd;
    logic          tx_full;
    logic          wr_tx;
    logic [7:0]    tx_data;
    logic [W-1:0]  alu_result;
    logic          alu_valid;
    logic          alu_start;
    logic [5:0]    alu_op;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic          busy;
    logic [7:0]    err_cnt;

    uart_alu_frame_if #(.N_OPB(2), .TIMEOUT_CYC(100)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_empty(rx_empty), .rd(rd),
        .tx_full(tx_full), .wr_tx(wr_tx), .tx_data(tx_data),
        .alu_result(alu_result), .alu_valid(alu_valid), .alu_start(alu_start),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .busy(busy), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] rxq[$];
    logic [7:0] exp_tx[$];
    logic [7:0] tx_log[$];
    int n_checks = 0;
    int n_fail = 0;
    int start_cnt = 0;
    int exp_starts = 0;
    int exp_err = 0;
    int spur_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: checksum decides ACK + sum bytes, or NAK + error
    task automatic model_frame(input logic [7:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [7:0] chk);
        logic [7:0]  x;
        logic [15:0] sum;
        x   = op ^ a[15:8] ^ a[7:0] ^ b[15:8] ^ b[7:0];
        sum = a + b;
        if (x == chk) begin
            exp_tx.push_back(8'h06);
            exp_tx.push_back(sum[15:8]);
            exp_tx.push_back(sum[7:0]);
            exp_starts++;
        end else begin
            exp_tx.push_back(8'h15);
            if (exp_err < 255) exp_err++;
        end
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [15:0] a,
                              input logic [15:0] b, input logic [7:0] chk);
        rxq.push_back(8'hFF);
        rxq.push_back(op);
        rxq.push_back(a[15:8]);
        rxq.push_back(a[7:0]);
        rxq.push_back(b[15:8]);
        rxq.push_back(b[7:0]);
        rxq.push_back(chk);
        model_frame(op, a, b, chk);
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clk);
            if (!busy && exp_tx.size() == 0 && rxq.size() == 0) done = 1'b1;
        end
        check({name, "_idle_reached"}, 32'(done), 32'd1);
    endtask

    task automatic check_log(input string name, input int n,
                             input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [7:0] e[3];
        e[0] = b0; e[1] = b1; e[2] = b2;
        check({name, "_tx_count"}, 32'(tx_log.size()), 32'(n));
        for (int i = 0; i < n && i < tx_log.size(); i++)
            check({name, "_tx_byte"}, 32'(tx_log[i]), 32'(e[i]));
    endtask

    task automatic check_totals(input string name);
        check({name, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        check({name, "_alu_starts"}, 32'(start_cnt), 32'(exp_starts));
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    // RX FIFO model (first-word-fall-through)
    initial begin
        bit pop;
        rx_data  = '0;
        rx_empty = 1'b1;
        forever begin
            @(negedge clk);
            pop = rd;
            @(posedge clk);
            #1;
            if (pop && rxq.size() > 0) void'(rxq.pop_front());
            rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
            rx_empty = (rxq.size() == 0);
        end
    end

    // ALU stub: result three cycles after start; also injects stray alu_valid on request
    initial begin
        int          cnt;
        int          spur_done;
        logic [15:0] pend;
        cnt = 0; spur_done = 0; pend = '0;
        alu_valid  = 1'b0;
        alu_result = '0;
        forever begin
            @(negedge clk);
            if (alu_start) begin
                start_cnt++;
                cnt  = 3;
                pend = alu_a + alu_b;
            end
            @(posedge clk);
            #1;
            alu_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    alu_valid  = 1'b1;
                    alu_result = pend;
                end
            end else if (spur_req != spur_done) begin
                spur_done++;
                alu_valid  = 1'b1;
                alu_result = 16'hDEAD;
            end
        end
    end

    // Per-cycle compare against the model's expected TX stream
    initial begin
        forever begin
            @(negedge clk);
            if (tx_full) check("wr_tx_while_full", 32'(wr_tx), 32'd0);
            if (rx_empty) check("rd_while_empty", 32'(rd), 32'd0);
            if (wr_tx && !tx_full) begin
                if (exp_tx.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_tx: got %0h, expected no write at %0t", tx_data, $time);
                end else begin
                    check("tx_byte_model", 32'(tx_data), 32'(exp_tx.pop_front()));
                end
                tx_log.push_back(tx_data);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        reset   = 1'b1;
        tx_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_tx", 32'(wr_tx), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // 1: basic add
        tx_log.delete();
        send_frame(8'h20, 16'h1234, 16'h0101, 8'h06);
        wait_idle("t1", 300);
        check_log("t1", 3, 8'h06, 8'h13, 8'h35);
        check("t1_alu_op", 32'(alu_op), 32'h20);
        check("t1_alu_a", 32'(alu_a), 32'h1234);
        check("t1_alu_b", 32'(alu_b), 32'h0101);
        check("t1_starts_lit", 32'(start_cnt), 32'd1);
        check_totals("t1");

        // 2: bad checksum
        tx_log.delete();
        send_frame(8'h20, 16'h1234, 16'h0101, 8'h07);
        wait_idle("t2", 300);
        check_log("t2", 1, 8'h15, 8'h00, 8'h00);
        check("t2_err_lit", 32'(err_cnt), 32'd1);
        check_totals("t2");

        // 3: junk before START is dropped
        tx_log.delete();
        rxq.push_back(8'hAA);
        rxq.push_back(8'h55);
        send_frame(8'h20, 16'h1234, 16'h0101, 8'h06);
        wait_idle("t3", 300);
        check_log("t3", 3, 8'h06, 8'h13, 8'h35);
        check_totals("t3");

        // 3b: START value inside a frame is data
        tx_log.delete();
        send_frame(8'h05, 16'hFF00, 16'h00FF, 8'h05);
        wait_idle("t3b", 300);
        check_log("t3b", 3, 8'h06, 8'hFF, 8'hFF);
        check_totals("t3b");

        // stray alu_valid while idle is ignored
        tx_log.delete();
        spur_req++;
        repeat (6) @(negedge clk);
        check("spur_tx_count", 32'(tx_log.size()), 32'd0);
        check("spur_busy", 32'(busy), 32'd0);

        // 4: inter-byte timeout
        tx_log.delete();
        rxq.push_back(8'hFF);
        rxq.push_back(8'h20);
        rxq.push_back(8'h12);
        repeat (90) @(negedge clk);
        check("t4_busy_before_timeout", 32'(busy), 32'd1);
        repeat (15) @(negedge clk);
        exp_err++;
        check("t4_busy_after_timeout", 32'(busy), 32'd0);
        check("t4_err_lit", 32'(err_cnt), 32'd2);
        check("t4_tx_count", 32'(tx_log.size()), 32'd0);
        send_frame(8'hC1, 16'hABCD, 16'h1111, 8'hA7);
        wait_idle("t4", 300);
        check_log("t4", 3, 8'h06, 8'hBC, 8'hDE);
        check("t4_alu_op", 32'(alu_op), 32'h01);
        check_totals("t4");

        // 5: TX backpressure during result bytes
        tx_log.delete();
        send_frame(8'h20, 16'h1234, 16'h0101, 8'h06);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            if (tx_log.size() == 1) seen = 1'b1;
        end
        check("t5_status_seen", 32'(seen), 32'd1);
        @(posedge clk); #1 tx_full = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("t5_wr_tx_held", 32'(wr_tx), 32'd0);
        end
        check("t5_busy_stalled", 32'(busy), 32'd1);
        @(posedge clk); #1 tx_full = 1'b0;
        wait_idle("t5", 300);
        check_log("t5", 3, 8'h06, 8'h13, 8'h35);
        check_totals("t5");

        // 6: reset mid-frame
        tx_log.delete();
        rxq.push_back(8'hFF);
        rxq.push_back(8'h20);
        rxq.push_back(8'h12);
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (rxq.size() == 0) seen = 1'b1;
        end
        check("t6_bytes_consumed", 32'(seen), 32'd1);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        exp_err = 0;
        @(negedge clk);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_alu_a", 32'(alu_a), 32'd0);
        check("t6_alu_b", 32'(alu_b), 32'd0);
        check("t6_alu_op", 32'(alu_op), 32'd0);
        check("t6_err_cnt", 32'(err_cnt), 32'd0);
        check("t6_wr_tx", 32'(wr_tx), 32'd0);
        send_frame(8'h20, 16'h1234, 16'h0101, 8'h06);
        wait_idle("t6", 300);
        check_log("t6", 3, 8'h06, 8'h13, 8'h35);
        check_totals("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
